// File: rtl/agu_issue_arbiter_if.sv
// AGU issue arbiter bus: requester inputs, flush/stall controls and issue slot.
// master drives the requests, slave is the arbiter.
interface agu_issue_arbiter_if #(
    parameter int NUM_REQ   = 2,
    parameter int SQN_W     = 7,
    parameter int PAYLOAD_W = 192
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                           IN_stall;
    logic                           IN_branch_taken;
    logic [SQN_W-1:0]               IN_branch_sqN;
    logic [NUM_REQ-1:0]             IN_valid;
    logic [NUM_REQ*SQN_W-1:0]       IN_sqN;
    logic [NUM_REQ*PAYLOAD_W-1:0]   IN_payload;
    logic [NUM_REQ-1:0]             OUT_ready;
    logic                           OUT_en;
    logic                           OUT_valid;
    logic [SQN_W-1:0]               OUT_sqN;
    logic [PAYLOAD_W-1:0]           OUT_payload;
    logic [GW-1:0]                  OUT_grantIdx;

    modport master (
        output IN_stall, IN_branch_taken, IN_branch_sqN,
        output IN_valid, IN_sqN, IN_payload,
        input  OUT_ready, OUT_en, OUT_valid,
        input  OUT_sqN, OUT_payload, OUT_grantIdx
    );

    modport slave (
        input  IN_stall, IN_branch_taken, IN_branch_sqN,
        input  IN_valid, IN_sqN, IN_payload,
        output OUT_ready, OUT_en, OUT_valid,
        output OUT_sqN, OUT_payload, OUT_grantIdx
    );
endinterface

// File: rtl/agu_issue_arbiter.sv
// Oldest-first load/store arbiter feeding a one-entry AGU issue slot,
// with per-requester starvation counters and mispredict flush.
module agu_issue_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int SQN_W     = 7,
    parameter int PAYLOAD_W = 192,
    parameter int MAX_WAIT  = 7
) (
    input  logic               clk,
    input  logic               rst,
    agu_issue_arbiter_if.slave bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    typedef logic [SQN_W-1:0]     sqn_t;
    typedef logic [PAYLOAD_W-1:0] pl_t;

    logic               slot_v;
    sqn_t               slot_sqn;
    pl_t                slot_pl;
    logic [GW-1:0]      slot_idx;
    logic [GW-1:0]      rr_ptr;
    logic [3:0]         wait_cnt [NUM_REQ];

    sqn_t               req_sqn [NUM_REQ];
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] starve;
    logic               slot_free;
    logic               found;
    logic               grant;
    logic [GW-1:0]      sel;
    logic [GW-1:0]      rr_nxt;
    sqn_t               best_sqn;
    sqn_t               diff;
    sqn_t               sel_sqn;
    pl_t                sel_pl;
    logic [NUM_REQ-1:0] ready;

    // Younger than the branch by wrap-around distance; the branch itself survives.
    function automatic logic killed(sqn_t x, sqn_t br, logic taken);
        sqn_t d;
        d = x - br;
        return taken && !d[SQN_W-1] && (d != '0);
    endfunction

    always_comb begin
        slot_free = !slot_v || !bus.IN_stall;
        for (int r = 0; r < NUM_REQ; r++) begin
            req_sqn[r] = bus.IN_sqN[r*SQN_W +: SQN_W];
            elig[r]    = bus.IN_valid[r] &&
                         !killed(req_sqn[r], bus.IN_branch_sqN,
                                 bus.IN_branch_taken);
            starve[r]  = elig[r] && (wait_cnt[r] >= WAIT_LIM);
        end
    end

    // Starved requesters win by index; otherwise scan from rr_ptr so
    // equal ages resolve to the pointer first, then upward.
    always_comb begin
        sel      = '0;
        found    = 1'b0;
        best_sqn = '0;
        diff     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (starve[i]) begin
                sel   = GW'(i);
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (elig[i] && ((int'(rr_ptr) + k) % NUM_REQ) == i) begin
                        diff = req_sqn[i] - best_sqn;
                        if (!found || diff[SQN_W-1]) begin
                            sel      = GW'(i);
                            best_sqn = req_sqn[i];
                            found    = 1'b1;
                        end
                    end
                end
            end
        end
        grant = found && slot_free && rst;
        ready = '0;
        if (grant) ready[sel] = 1'b1;
    end

    always_comb begin
        sel_sqn = '0;
        sel_pl  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == GW'(i)) begin
                sel_sqn = req_sqn[i];
                sel_pl  = bus.IN_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
        rr_nxt = (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_v   <= 1'b0;
            slot_sqn <= '0;
            slot_pl  <= '0;
            slot_idx <= '0;
            rr_ptr   <= '0;
            for (int r = 0; r < NUM_REQ; r++) wait_cnt[r] <= '0;
        end else begin
            if (grant) begin
                slot_v   <= 1'b1;
                slot_sqn <= sel_sqn;
                slot_pl  <= sel_pl;
                slot_idx <= sel;
                rr_ptr   <= rr_nxt;
            end else if (slot_free) begin
                slot_v <= 1'b0;
            end else if (killed(slot_sqn, bus.IN_branch_sqN,
                                bus.IN_branch_taken)) begin
                slot_v <= 1'b0;
            end
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!bus.IN_valid[r] || (grant && sel == GW'(r)))
                    wait_cnt[r] <= '0;
                else if (grant && wait_cnt[r] != 4'hF)
                    wait_cnt[r] <= wait_cnt[r] + 4'd1;
            end
        end
    end

    assign bus.OUT_ready    = ready;
    assign bus.OUT_en       = slot_v;
    assign bus.OUT_valid    = slot_v;
    assign bus.OUT_sqN      = slot_sqn;
    assign bus.OUT_payload  = slot_pl;
    assign bus.OUT_grantIdx = slot_idx;
endmodule

// File: tb/tb_agu_issue_arbiter.sv
// Bench for agu_issue_arbiter: reference model plus grant scoreboard.
// Directed scenarios followed by a random phase.
module tb_agu_issue_arbiter;
    localparam int PW = 192;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    agu_issue_arbiter_if #(.NUM_REQ(2), .SQN_W(7), .PAYLOAD_W(PW)) bus ();

    agu_issue_arbiter #(
        .NUM_REQ(2), .SQN_W(7), .PAYLOAD_W(PW), .MAX_WAIT(7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic          idx;
        logic [6:0]    sqn;
        logic [PW-1:0] pl;
    } exp_t;

    exp_t          sb [$];
    int            n_chk = 0;
    int            n_pass = 0;
    int            last_g;
    int            losses;
    logic          m_v;
    logic [6:0]    m_sqn;
    logic [PW-1:0] m_pl;
    logic          m_idx;
    logic          m_rr;
    logic [3:0]    m_w [2];

    task automatic check(string tag, logic [PW-1:0] got, logic [PW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [PW-1:0] rnd_pl();
        return {$urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic bit mkill(logic [6:0] x);
        logic [6:0] d;
        d = x - bus.IN_branch_sqN;
        return bus.IN_branch_taken && ($signed(d) > 0);
    endfunction

    task automatic mreset();
        m_v = 0; m_sqn = '0; m_pl = '0; m_idx = 0; m_rr = 0;
        m_w[0] = '0; m_w[1] = '0;
        sb.delete();
    endtask

    task automatic drive(logic [1:0] v, logic [6:0] s0, logic [6:0] s1,
                         logic st, logic bt, logic [6:0] bs);
        bus.IN_valid        = v;
        bus.IN_sqN          = {s1, s0};
        bus.IN_payload      = {rnd_pl(), rnd_pl()};
        bus.IN_stall        = st;
        bus.IN_branch_taken = bt;
        bus.IN_branch_sqN   = bs;
    endtask

    // Called just after a negedge with inputs driven; returns at next negedge.
    task automatic cycle();
        logic       e0, e1, free;
        logic [6:0] s0, s1, d;
        logic [1:0] er;
        int         g;
        exp_t       e;
        #1;
        s0   = bus.IN_sqN[6:0];
        s1   = bus.IN_sqN[13:7];
        e0   = bus.IN_valid[0] && !mkill(s0);
        e1   = bus.IN_valid[1] && !mkill(s1);
        free = !m_v || !bus.IN_stall;
        g    = -1;
        if (free && rst) begin
            if (e0 && m_w[0] >= 4'd7) g = 0;
            else if (e1 && m_w[1] >= 4'd7) g = 1;
            else if (e0 && e1) begin
                d = s0 - s1;
                if (d == 7'd0) g = int'(m_rr);
                else g = ($signed(d) < 0) ? 0 : 1;
            end
            else if (e0) g = 0;
            else if (e1) g = 1;
        end
        er = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
        check("ready", bus.OUT_ready, er);
        if (g == 0) sb.push_back({1'b0, s0, bus.IN_payload[PW-1:0]});
        if (g == 1) sb.push_back({1'b1, s1, bus.IN_payload[2*PW-1:PW]});
        @(posedge clk);
        if (g >= 0) begin
            m_v  = 1;
            m_rr = (g == 0);
        end else if (free) m_v = 0;
        else if (mkill(m_sqn)) m_v = 0;
        for (int r = 0; r < 2; r++) begin
            if (!bus.IN_valid[r] || g == r) m_w[r] = '0;
            else if (g >= 0 && m_w[r] != 4'hF) m_w[r] = m_w[r] + 4'd1;
        end
        last_g = g;
        #1;
        check("valid", bus.OUT_valid, m_v);
        check("en", bus.OUT_en, m_v);
        if (g >= 0 && sb.size() > 0) begin
            e = sb.pop_front();
            m_sqn = e.sqn;
            m_pl  = e.pl;
            m_idx = e.idx;
        end
        if (m_v) begin
            check("sqn", bus.OUT_sqN, m_sqn);
            check("payload", bus.OUT_payload, m_pl);
            check("grant_idx", bus.OUT_grantIdx, m_idx);
        end
        @(negedge clk);
    endtask

    initial begin
        mreset();
        drive(2'b11, 7'h05, 7'h09, 0, 0, 7'h00);
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", bus.OUT_ready, 0);
        check("rst_valid", bus.OUT_valid, 0);
        check("rst_en", bus.OUT_en, 0);
        check("rst_sqn", bus.OUT_sqN, 0);
        check("rst_payload", bus.OUT_payload, 0);
        check("rst_idx", bus.OUT_grantIdx, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(2'b11, 7'h05, 7'h09, 0, 0, 7'h00);
        cycle();
        check("first_grant", bus.OUT_sqN, 7'h05);

        drive(2'b11, 7'h7E, 7'h02, 0, 0, 7'h00);
        cycle();
        check("wrap_g", last_g, 0);
        check("wrap_sqn", bus.OUT_sqN, 7'h7E);

        drive(2'b01, 7'h10, 7'h00, 0, 0, 7'h00);
        cycle();
        repeat (3) begin
            drive(2'b10, 7'h00, 7'h11, 1, 0, 7'h00);
            cycle();
            check("stall_hold", bus.OUT_sqN, 7'h10);
        end
        drive(2'b10, 7'h00, 7'h11, 1, 1, 7'h10);
        cycle();
        check("br_eq_keep", bus.OUT_valid, 1);
        drive(2'b10, 7'h00, 7'h11, 1, 1, 7'h0C);
        cycle();
        check("br_flush", bus.OUT_valid, 0);
        drive(2'b10, 7'h00, 7'h11, 1, 0, 7'h00);
        cycle();
        check("empty_fill", bus.OUT_sqN, 7'h11);

        drive(2'b11, 7'h21, 7'h25, 0, 1, 7'h22);
        cycle();
        check("kill_g", last_g, 0);
        drive(2'b11, 7'h23, 7'h25, 0, 1, 7'h20);
        cycle();
        check("all_killed", bus.OUT_valid, 0);

        drive(2'b00, 7'h00, 7'h00, 0, 0, 7'h00);
        cycle();
        losses = 0;
        for (int i = 0; i < 12; i++) begin
            drive(2'b11, 7'(7'h40 + i), 7'h60, 0, 0, 7'h00);
            cycle();
            if (last_g == 1) break;
            losses++;
        end
        check("starve_losses", losses, 7);

        drive(2'b11, 7'h30, 7'h30, 0, 0, 7'h00);
        cycle();
        check("tie_g0", last_g, 0);
        drive(2'b11, 7'h30, 7'h30, 0, 0, 7'h00);
        cycle();
        check("tie_g1", last_g, 1);

        for (int i = 0; i < 300; i++) begin
            drive(2'($urandom_range(0, 3)), 7'($urandom_range(0, 15)),
                  7'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0, 7'($urandom_range(0, 15)));
            cycle();
        end

        drive(2'b01, 7'h05, 7'h00, 0, 0, 7'h00);
        cycle();
        rst = 1'b0;
        #1;
        check("midrst_valid", bus.OUT_valid, 0);
        check("midrst_ready", bus.OUT_ready, 0);
        check("midrst_payload", bus.OUT_payload, 0);
        mreset();
        @(negedge clk);
        rst = 1'b1;
        drive(2'b11, 7'h09, 7'h08, 0, 0, 7'h00);
        cycle();
        check("post_rst_g", last_g, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/agu_issue_arbiter.md
# agu_issue_arbiter

Oldest-first issue arbiter that shares the single AGU between the load and store issue queues. Each cycle it picks one eligible uop, registers it into a one-entry issue slot that drives the AGU input, and honours AGU stall backpressure and branch-mispredict flushes. A per-requester starvation counter guarantees forward progress when one queue keeps presenting older uops.

## Interface
- `NUM_REQ`, 2, number of requesters (index 0 = load IQ, 1 = store IQ)
- `SQN_W`, 7, sequence-number width
- `PAYLOAD_W`, 192, opaque uop payload bits forwarded unchanged
- `MAX_WAIT`, 7, consecutive lost arbitrations before forced grant (1..15)
- `clk` in 1 — clock, all state on rising edge
- `rst` in 1 — asynchronous, active-low reset
- `IN_stall` in 1 — AGU cannot accept this cycle
- `IN_branch_taken` in 1 — mispredict flush valid this cycle
- `IN_branch_sqN` in SQN_W — sqN of the mispredicting branch
- `IN_valid` in NUM_REQ — requester r presents a uop
- `IN_sqN` in NUM_REQ*SQN_W — sqN per requester (r at `[r*SQN_W +: SQN_W]`)
- `IN_payload` in NUM_REQ*PAYLOAD_W — payload per requester
- `OUT_ready` out NUM_REQ — one-hot; requester r's uop is taken at this edge
- `OUT_en` out 1 — AGU enable (= `OUT_valid`)
- `OUT_valid` out 1 — issue slot holds a live uop
- `OUT_sqN` out SQN_W — slot sqN
- `OUT_payload` out PAYLOAD_W — slot payload
- `OUT_grantIdx` out 1 (log2 NUM_REQ, min 1) — requester that filled the slot

## Operation
- Killed(x): `IN_branch_taken && $signed(x - IN_branch_sqN) > 0` (SQN_W-bit wrap difference, signed).
- Eligible r: `IN_valid[r] && !Killed(IN_sqN[r])`.
- Slot free: `!OUT_valid || !IN_stall`.
- Selection, when slot free and ≥1 eligible:
  - If any eligible r has `waitCnt[r] >= MAX_WAIT`, pick the lowest such index.
  - Otherwise pick the eligible r with the smallest `$signed(IN_sqN[r] - IN_sqN[other])` (oldest). Ties go to the round-robin pointer `rrPtr`, then upward index order.
- `OUT_ready` is combinational from the current-cycle inputs and state. At most one bit is set, and only when the slot is free.
- Edge update:
  - Grant r: slot ← {1, sqN, payload}, `OUT_grantIdx` ← r, `rrPtr` ← r+1 mod NUM_REQ, `waitCnt[r]` ← 0.
  - No grant, slot free: `OUT_valid` ← 0.
  - Slot not free (stalled): hold all slot fields. However, if Killed(`OUT_sqN`), `OUT_valid` ← 0 (flush beats stall).
- `waitCnt[r]` (4-bit, saturating at 15):
  - +1 when `IN_valid[r]` and the slot is free but another requester is granted.
  - Cleared when r is granted or `IN_valid[r]` = 0.
  - Held otherwise.
- Branch and grant in the same cycle: killed uops are never granted. A non-killed uop is granted normally.
- The branch sqN itself (difference = 0) is not killed.

## Timing
- Reset values (async assert, sync release on next edge): `OUT_valid`=0, `OUT_en`=0, `OUT_sqN`=0, `OUT_payload`=0, `OUT_grantIdx`=0, `rrPtr`=0, all `waitCnt`=0, `OUT_ready`=0 while `rst`=0.
- Latency: uop accepted at edge N appears on `OUT_*` during cycle N+1 (one register stage).
- Throughput: one uop per cycle when `IN_stall`=0.
- Handshake:
  - Requester must hold valid/sqN/payload stable until it sees `OUT_ready[r]`=1 at an edge.
  - The uop is consumed at that edge.
  - The requester may drop valid without a grant (flushed upstream).
- Stall: while `IN_stall`=1 and `OUT_valid`=1, the slot is frozen and `OUT_ready`=0. With `IN_stall`=1 and `OUT_valid`=0, the empty slot still fills.
- Reset mid-operation: slot content discarded immediately; no partial uop survives.

## Test plan
- Reset hold: `rst`=0 with `IN_valid`=2'b11 → `OUT_ready`=0, `OUT_valid`=0. Release → first grant on the next edge, `OUT_valid`=1 the cycle after.
- Oldest-first with wrap: req0 sqN=0x7E, req1 sqN=0x02, no stall → `OUT_ready`=2'b01 (0x7E older across wrap). Next cycle `OUT_sqN`=0x7E, `OUT_grantIdx`=0.
- Stall then flush: slot holds sqN=0x10, `IN_stall`=1 for 3 cycles → outputs unchanged, `OUT_ready`=0. Branch sqN=0x0C taken → `OUT_valid`=0 next cycle. With branch sqN=0x10, the slot is kept.
- Same-cycle kill: req0 sqN=0x21, req1 sqN=0x25, branch sqN=0x22 taken, slot free → req0 granted, `OUT_ready`=2'b01. Req1 is never granted that cycle.
- Starvation: req1 held valid with the younger sqN while req0 streams older uops each cycle, `MAX_WAIT`=7 → req1 loses 7 times, then is granted on the 8th cycle. `waitCnt[1]` returns to 0.
- Tie round-robin: both sqN=0x30 for two consecutive grants → grants go to req0 then req1 (`rrPtr` 0→1→0).
